// File: rtl/rr_sched4.sv
// Four-client round-robin scheduler for one shared resource: rotating 2-bit priority pointer,
// exclusive one-hot grant, release on done/withdraw (plus hold timeout when RR_SCHED4_TIMEOUT_EN is defined).
module rr_sched4 #(
    parameter int unsigned HOLD_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t     state_q;
    logic [1:0] ptr_q;
    logic [3:0] gnt_q;
    logic [1:0] gnt_id_q;
    logic       busy_q;

    logic [3:0] req_rot;
    logic [1:0] win_off;
    logic [1:0] winner;
    logic       owner_req;
    logic       hold_expired;
    logic       release_now;

    if (HOLD_CYCLES < 2 || HOLD_CYCLES > 255) begin : g_bad_hold
        $error("rr_sched4: HOLD_CYCLES must be within 2..255");
    end

    // req_rot[k] is the request of the client k places after the pointer, so the
    // lowest set bit is the round-robin winner.
    for (genvar gi = 0; gi < 4; gi++) begin : g_rot
        assign req_rot[gi] = req[ptr_q + 2'(gi)];
    end

    always_comb begin
        win_off = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (req_rot[k]) begin
                win_off = 2'(k);
            end
        end
    end

    assign winner      = ptr_q + win_off;
    assign owner_req   = req[gnt_id_q];
    assign release_now = done || !owner_req || hold_expired;

`ifdef RR_SCHED4_TIMEOUT_EN
    logic [7:0] hold_q;
    logic       timeout_q;

    assign hold_expired = (hold_q == 8'(HOLD_CYCLES - 1));
    assign timeout      = timeout_q;
`else
    assign hold_expired = 1'b0;
    assign timeout      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= 2'd0;
            gnt_q     <= 4'b0000;
            gnt_id_q  <= 2'd0;
            busy_q    <= 1'b0;
`ifdef RR_SCHED4_TIMEOUT_EN
            hold_q    <= 8'd0;
            timeout_q <= 1'b0;
`endif
        end else begin
`ifdef RR_SCHED4_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (|req) begin
                        state_q  <= S_GRANT;
                        gnt_q    <= 4'b0001 << winner;
                        gnt_id_q <= winner;
                        busy_q   <= 1'b1;
`ifdef RR_SCHED4_TIMEOUT_EN
                        hold_q   <= 8'd0;
`endif
                    end
                end
                S_GRANT: begin
                    if (release_now) begin
                        state_q <= S_IDLE;
                        gnt_q   <= 4'b0000;
                        busy_q  <= 1'b0;
                        ptr_q   <= gnt_id_q + 2'd1;
`ifdef RR_SCHED4_TIMEOUT_EN
                        // The pulse is only for a revocation the timer alone caused.
                        timeout_q <= hold_expired && !done && owner_req;
`endif
                    end else begin
`ifdef RR_SCHED4_TIMEOUT_EN
                        if (hold_q != 8'hFF) begin
                            hold_q <= hold_q + 8'd1;
                        end
`endif
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt    = gnt_q;
    assign gnt_id = gnt_id_q;
    assign busy   = busy_q;

endmodule
